fpu_op_sequencer: RTL and testbench

Operand-issue and result-capture stage that wraps the `fpu` adder. It accepts operand pairs through a valid/ready handshake and queues them in a small FIFO. It presents one pair at a time on the FPU operand inputs, holds that pair stable for a fixed settle window, then captures `data_out`/`status_out` into a result register with its own valid/ready handshake. The FPU has no start/done strobes, so this block is what guarantees that every captured result belongs to the operands currently driven.

---
 rtl/fpu_pkg.sv | 18 +
 rtl/fpu_op_fifo.sv | 47 ++++
 rtl/fpu_op_sequencer.sv | 107 ++++++++++
 tb/tb_fpu_op_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared widths, status codes, sequencer states and small helpers
package fpu_pkg;
  localparam int WORD_W = 32;
  localparam int EXP_W = 6;
  localparam int MANT_W = 25;
  localparam logic [3:0] ST_EXACT = 4'b0001;
  localparam logic [3:0] ST_INEXACT = 4'b0010;
  localparam logic [3:0] ST_OVF = 4'b0100;
  localparam logic [3:0] ST_UNF = 4'b1000;
  localparam logic [3:0] ST_BAD = 4'b0000;
  typedef enum logic [1:0] {IDLE, WAIT, RESULT} seq_state_t;
  function automatic logic is_onehot(input logic [3:0] s);
    return (s != 4'd0) && ((s & (s - 4'd1)) == 4'd0);
  endfunction
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction
endpackage

// File: rtl/fpu_op_fifo.sv
// fpu_op_fifo: synchronous operand-pair FIFO; push refused when full, pop ignored when empty
module fpu_op_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = 2 * WORD_W
) (
  input  logic         clock100KHz,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW + 1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign dout_o = mem_q[rd_q];
  // pointer and occupancy next-state; full/empty come from registered count only
  always_comb begin
    do_push = push_i && !full_o;
    do_pop = pop_i && !empty_o;
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
  end
  // storage and pointers, cleared on reset so queued pairs are discarded
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= din_i;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: queues operand pairs, holds each on the FPU for a settle window, captures the result
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WAIT_CYCLES = 64
) (
  input  logic              clock100KHz,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  output logic [WORD_W-1:0] fpu_op_a,
  output logic [WORD_W-1:0] fpu_op_b,
  input  logic [WORD_W-1:0] fpu_data,
  input  logic [3:0]        fpu_status,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WORD_W-1:0] res_data,
  output logic [3:0]        res_status,
  output logic              busy,
  input  logic              cnt_clear,
  output logic [7:0]        ovf_cnt,
  output logic [7:0]        unf_cnt,
  output logic [7:0]        inx_cnt
);
  localparam int CW = $clog2(WAIT_CYCLES);
  seq_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, rd_q, rd_d;
  logic [3:0] rs_q, rs_d, st_chk;
  logic rv_q, rv_d, init_q;
  logic [7:0] ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;
  logic full, empty, pop, capture;
  logic [2*WORD_W-1:0] fifo_dout;
  fpu_op_fifo #(.DEPTH(DEPTH), .W(2 * WORD_W)) u_fifo (
    .clock100KHz(clock100KHz),
    .reset(reset),
    .push_i(in_valid && in_ready),
    .pop_i(pop),
    .din_i({in_a, in_b}),
    .dout_o(fifo_dout),
    .full_o(full),
    .empty_o(empty)
  );
  assign in_ready = init_q && !full;
  assign busy = state_q != IDLE;
  assign fpu_op_a = op_a_q;
  assign fpu_op_b = op_b_q;
  assign res_valid = rv_q;
  assign res_data = rd_q;
  assign res_status = rs_q;
  assign ovf_cnt = ovf_q;
  assign unf_cnt = unf_q;
  assign inx_cnt = inx_q;
  // next-state: pop only in IDLE, count down the settle window, capture when it expires
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!empty) state_d = WAIT;
      WAIT: if (cnt_q == '0) state_d = RESULT;
      RESULT: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pop = state_q == IDLE && !empty;
    capture = state_q == WAIT && cnt_q == '0;
    st_chk = is_onehot(fpu_status) ? fpu_status : ST_BAD;
    op_a_d = pop ? fifo_dout[2*WORD_W-1:WORD_W] : op_a_q;
    op_b_d = pop ? fifo_dout[WORD_W-1:0] : op_b_q;
    cnt_d = pop ? CW'(WAIT_CYCLES - 1) : (state_q == WAIT && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    rv_d = capture ? 1'b1 : (state_q == RESULT && res_ready) ? 1'b0 : rv_q;
    rd_d = capture ? fpu_data : rd_q;
    rs_d = capture ? st_chk : rs_q;
    ovf_d = cnt_clear ? 8'd0 : (capture && st_chk == ST_OVF) ? sat_inc(ovf_q) : ovf_q;
    unf_d = cnt_clear ? 8'd0 : (capture && st_chk == ST_UNF) ? sat_inc(unf_q) : unf_q;
    inx_d = cnt_clear ? 8'd0 : (capture && st_chk == ST_INEXACT) ? sat_inc(inx_q) : inx_q;
  end
  // state and datapath registers; init_q keeps in_ready low until the first edge after reset
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      rv_q <= 1'b0;
      rd_q <= '0;
      rs_q <= '0;
      ovf_q <= '0;
      unf_q <= '0;
      inx_q <= '0;
      init_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      rv_q <= rv_d;
      rd_q <= rd_d;
      rs_q <= rs_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      inx_q <= inx_d;
      init_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb_fpu_op_sequencer: directed checks of issue timing, capture, counters, back-pressure and reset
module tb_fpu_op_sequencer;
  import fpu_pkg::*;
  logic clock100KHz = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0, in_ready, res_valid, res_ready = 1'b0, busy, cnt_clear = 1'b0;
  logic [31:0] in_a = '0, in_b = '0, fpu_op_a, fpu_op_b, fpu_data, res_data;
  logic [3:0] fpu_status, res_status;
  logic [7:0] ovf_cnt, unf_cnt, inx_cnt;
  logic use_model = 1'b0;
  logic [31:0] data_r = '0;
  logic [3:0] status_r = ST_EXACT;
  logic [31:0] exp_bp [4] = '{32'd7, 32'd11, 32'd15, 32'd19};
  int checks = 0, errors = 0;
  always #5 clock100KHz = ~clock100KHz;
  assign fpu_data = use_model ? fpu_op_a + fpu_op_b : data_r;
  assign fpu_status = use_model ? ST_EXACT : status_r;
  fpu_op_sequencer #(.DEPTH(4), .WAIT_CYCLES(64)) dut (
    .clock100KHz(clock100KHz), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b),
    .fpu_data(fpu_data), .fpu_status(fpu_status), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_status(res_status), .busy(busy), .cnt_clear(cnt_clear),
    .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt), .inx_cnt(inx_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock100KHz);
    #1;
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    tick;
    in_valid = 1'b0;
  endtask
  task automatic wait_valid(input int bound);
    int n;
    n = 0;
    while (!res_valid && n < bound) begin
      tick;
      n++;
    end
  endtask
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] od, output logic [3:0] os,
                       output logic ok);
    data_r = d;
    status_r = s;
    push(a, b);
    wait_valid(200);
    ok = res_valid;
    od = res_data;
    os = res_status;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
  endtask
  initial begin
    logic [31:0] od;
    logic [3:0] os;
    logic ok;
    repeat (3) tick;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_a", fpu_op_a, 0);
    chk("rst_ovf", ovf_cnt, 0);
    reset = 1'b1;
    tick;
    chk("post_rst_in_ready", in_ready, 1);
    data_r = 32'h42000000;
    status_r = ST_EXACT;
    push(32'h40000000, 32'h40000000);
    chk("exact_busy_before_pop", busy, 0);
    tick;
    chk("exact_busy_after_pop", busy, 1);
    chk("exact_op_a", fpu_op_a, 32'h40000000);
    chk("exact_op_b", fpu_op_b, 32'h40000000);
    repeat (63) tick;
    chk("exact_valid_at_63", res_valid, 0);
    tick;
    chk("exact_valid_at_64", res_valid, 1);
    chk("exact_data", res_data, 32'h42000000);
    chk("exact_status", res_status, 32'(ST_EXACT));
    tick;
    chk("exact_hold", res_valid, 1);
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    chk("exact_valid_cleared", res_valid, 0);
    chk("exact_idle", busy, 0);
    chk("exact_op_hold", fpu_op_a, 32'h40000000);
    do_op(32'h0, 32'h0, 32'h0, ST_EXACT, od, os, ok);
    chk("zero_valid", ok, 1);
    chk("zero_data", od, 0);
    chk("zero_status", os, 32'(ST_EXACT));
    chk("zero_cnts", {ovf_cnt, unf_cnt, inx_cnt}, 0);
    do_op(32'h7E000000, 32'h7E000000, 32'h0, ST_OVF, od, os, ok);
    chk("ovf_valid", ok, 1);
    chk("ovf_data", od, 0);
    chk("ovf_status", os, 32'(ST_OVF));
    chk("ovf_cnt_1", ovf_cnt, 1);
    for (int i = 0; i < 299; i++) do_op(32'h7E000000, 32'h7E000000, 32'h0, ST_OVF, od, os, ok);
    chk("ovf_cnt_sat", ovf_cnt, 255);
    cnt_clear = 1'b1;
    tick;
    cnt_clear = 1'b0;
    chk("ovf_cleared", ovf_cnt, 0);
    do_op(32'h1, 32'h1, 32'h12345678, 4'b0011, od, os, ok);
    chk("bad_data", od, 32'h12345678);
    chk("bad_status", os, 32'(ST_BAD));
    chk("bad_no_count", {ovf_cnt, unf_cnt, inx_cnt}, 0);
    do_op(32'h1, 32'h1, 32'h0, ST_UNF, od, os, ok);
    chk("unf_cnt_1", unf_cnt, 1);
    do_op(32'h1, 32'h1, 32'h3, ST_INEXACT, od, os, ok);
    chk("inx_cnt_1", inx_cnt, 1);
    chk("inx_ovf_untouched", ovf_cnt, 0);
    use_model = 1'b1;
    push(32'd1, 32'd2);
    chk("bp_ready_1", in_ready, 1);
    push(32'd3, 32'd4);
    push(32'd5, 32'd6);
    push(32'd7, 32'd8);
    chk("bp_ready_4", in_ready, 1);
    push(32'd9, 32'd10);
    chk("bp_ready_full", in_ready, 0);
    chk("bp_first_issued", fpu_op_a, 32'd1);
    in_valid = 1'b1;
    in_a = 32'd100;
    in_b = 32'd200;
    repeat (3) tick;
    in_valid = 1'b0;
    chk("bp_still_full", in_ready, 0);
    wait_valid(200);
    chk("bp_valid_0", res_valid, 1);
    chk("bp_data_0", res_data, 32'd3);
    repeat (5) tick;
    chk("bp_stall", res_valid, 1);
    chk("bp_full_in_result", in_ready, 0);
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    chk("bp_full_in_idle", in_ready, 0);
    tick;
    chk("bp_ready_after_pop", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      wait_valid(200);
      chk("bp_valid_k", res_valid, 1);
      chk("bp_data_k", res_data, exp_bp[k]);
      res_ready = 1'b1;
      tick;
      res_ready = 1'b0;
    end
    repeat (2) tick;
    chk("bp_no_extra_pair", busy, 0);
    use_model = 1'b0;
    data_r = 32'hDEADBEEF;
    push(32'h11111111, 32'h22222222);
    push(32'h33333333, 32'h44444444);
    repeat (10) tick;
    chk("mid_wait_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_valid", res_valid, 0);
    chk("mr_op_a", fpu_op_a, 0);
    chk("mr_op_b", fpu_op_b, 0);
    chk("mr_in_ready", in_ready, 0);
    chk("mr_cnts", {ovf_cnt, unf_cnt, inx_cnt}, 0);
    chk("mr_res_data", res_data, 0);
    tick;
    reset = 1'b1;
    tick;
    chk("mr_ready_after", in_ready, 1);
    repeat (100) tick;
    chk("mr_no_stale_valid", res_valid, 0);
    chk("mr_no_stale_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
